// File: rtl/wand_arb_pkg.sv
// Shared types and constants for the wired-AND bus arbiter.
package wand_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        TURN = 2'd2
    } state_t;

    // All-ones pattern of width w (w <= 64); the wand identity value.
    function automatic logic [63:0] ones(input int unsigned w);
        ones = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_pick #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] onehot,
    output logic [IW-1:0]    idx,
    output logic             valid
);

    // Walk the rotated order from far to near so the nearest requester wins.
    always_comb begin
        int j;
        j      = 0;
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % int'(N_REQ);
            if (req[j]) begin
                valid = 1'b1;
                idx   = IW'(j);
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/wand_bus_arbiter.sv
// Round-robin owner of a shared wired-AND bus; non-owners are forced to all-ones.
module wand_bus_arbiter
    import wand_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          done,
    input  logic [N_REQ*DATA_W-1:0]   din,
    output logic [N_REQ-1:0]          gnt,
    output logic                      busy,
    output logic [DATA_W-1:0]         bus_out,
    output logic                      timeout
);

    localparam int unsigned IW = $clog2(N_REQ);
    localparam int unsigned CW = $clog2(HOLD_MAX + 1);
    localparam logic [DATA_W-1:0] ALL_ONES = DATA_W'(ones(DATA_W));

    state_t            state_q, state_d;
    logic [N_REQ-1:0]  gnt_d;
    logic              busy_d;
    logic [DATA_W-1:0] bus_d;
    logic              timeout_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     hold_q, hold_d;

    logic [N_REQ-1:0]  pick_onehot;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic [DATA_W-1:0] resolved;
    logic [IW-1:0]     next_ptr;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // Wired-AND of all drivers; only the granted slice can pull bits low.
    always_comb begin
        resolved = ALL_ONES;
        for (int i = 0; i < int'(N_REQ); i++) begin
            resolved = resolved & (gnt[i] ? din[i*DATA_W +: DATA_W] : ALL_ONES);
        end
    end

    assign next_ptr = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt      <= '0;
            busy     <= 1'b0;
            bus_out  <= ALL_ONES;
            timeout  <= 1'b0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            busy     <= busy_d;
            bus_out  <= bus_d;
            timeout  <= timeout_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        busy_d    = busy;
        bus_d     = bus_out;
        timeout_d = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                bus_d = ALL_ONES;
                if (pick_valid) begin
                    state_d = OWN;
                    gnt_d   = pick_onehot;
                    busy_d  = 1'b1;
                    owner_d = pick_idx;
                    hold_d  = '0;
                end
            end
            OWN: begin
                hold_d = hold_q + CW'(1);
                bus_d  = resolved;
                // Owner release has priority over the hold-limit timeout.
                if (done[owner_q] || !req[owner_q] || (hold_q == CW'(HOLD_MAX - 1))) begin
                    state_d   = TURN;
                    gnt_d     = '0;
                    busy_d    = 1'b0;
                    bus_d     = ALL_ONES;
                    rr_ptr_d  = next_ptr;
                    hold_d    = '0;
                    timeout_d = !(done[owner_q] || !req[owner_q]);
                end
            end
            TURN: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                bus_d   = ALL_ONES;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                bus_d   = ALL_ONES;
            end
        endcase
    end

endmodule

// File: tb/tb_wand_bus_arbiter.sv
// Directed bench for wand_bus_arbiter with hand-computed expectations.
module tb_wand_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        busy;
    logic [7:0]  bus_out;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    wand_bus_arbiter #(
        .N_REQ    (4),
        .DATA_W   (8),
        .HOLD_MAX (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .din     (din),
        .gnt     (gnt),
        .busy    (busy),
        .bus_out (bus_out),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst  = 1'b1;
        req  = '0;
        done = '0;
        din  = '1;
        #2;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_bus", 32'(bus_out), 32'hFF);
        check("rst_timeout", 32'(timeout), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: idle with no requests
        for (int c = 0; c < 5; c++) begin
            tick();
            check("idle_gnt", 32'(gnt), 32'h0);
            check("idle_busy", 32'(busy), 32'h0);
            check("idle_bus", 32'(bus_out), 32'hFF);
        end

        // 2: single requester 2, unused slices are X
        din  = 32'hxxA5xxxx;
        req  = 4'b0100;
        tick();
        check("t2_gnt", 32'(gnt), 32'h4);
        check("t2_busy", 32'(busy), 32'h1);
        check("t2_bus_lag", 32'(bus_out), 32'hFF);
        tick();
        check("t2_bus", 32'(bus_out), 32'hA5);
        done = 4'b0100;
        tick();
        done = '0;
        req  = '0;
        check("t2_turn_gnt", 32'(gnt), 32'h0);
        check("t2_turn_busy", 32'(busy), 32'h0);
        check("t2_turn_bus", 32'(bus_out), 32'hFF);
        check("t2_turn_to", 32'(timeout), 32'h0);
        tick();
        check("t2_idle_gnt", 32'(gnt), 32'h0);
        // rr_ptr should now be 3: with 0,1,3 requesting, 3 wins
        req = 4'b1011;
        tick();
        check("t2_ptr3", 32'(gnt), 32'h8);
        done = 4'b1000;
        tick();
        done = '0;
        req  = '0;
        check("t2_ptr3_rel", 32'(gnt), 32'h0);
        tick();
        #1 rst = 1'b1;
        #2 rst = 1'b0;

        // 3: everyone requesting, round-robin order from 0
        din = 32'h44332211;
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_gnt = 4'b0001 << order[n];
            tick();
            check("t3_gnt", 32'(gnt), 32'(exp_gnt));
            check("t3_onehot", 32'($onehot0(gnt)), 32'h1);
            tick();
            check("t3_hold", 32'(gnt), 32'(exp_gnt));
            done = exp_gnt;
            tick();
            done = '0;
            check("t3_turn", 32'(gnt), 32'h0);
            tick();
            check("t3_idle", 32'(gnt), 32'h0);
        end
        req = '0;
        tick();

        // 4: requester 1 holds without done until the hold limit
        din = 32'hxxxx5Axx;
        req = 4'b0010;
        tick();
        check("t4_gnt", 32'(gnt), 32'h2);
        for (int c = 0; c < 15; c++) begin
            tick();
            check("t4_own", 32'(gnt), 32'h2);
            check("t4_no_to", 32'(timeout), 32'h0);
        end
        check("t4_bus", 32'(bus_out), 32'h5A);
        tick();
        check("t4_to_gnt", 32'(gnt), 32'h0);
        check("t4_to", 32'(timeout), 32'h1);
        check("t4_to_bus", 32'(bus_out), 32'hFF);
        tick();
        check("t4_to_clr", 32'(timeout), 32'h0);
        check("t4_idle", 32'(gnt), 32'h0);
        tick();
        check("t4_regrant", 32'(gnt), 32'h2);
        req = '0;
        tick();
        check("t4_drop", 32'(gnt), 32'h0);
        check("t4_drop_to", 32'(timeout), 32'h0);
        tick();

        // 5: owner 0 with aggressive non-owner slices
        din = 32'h0F00003C;
        req = 4'b0001;
        tick();
        check("t5_gnt", 32'(gnt), 32'h1);
        tick();
        check("t5_bus", 32'(bus_out), 32'h3C);
        din  = 32'h0F0000C3;
        done = 4'b0010;
        tick();
        done = '0;
        check("t5_bus2", 32'(bus_out), 32'hC3);
        check("t5_nonowner_done", 32'(gnt), 32'h1);

        // 6: asynchronous reset in the middle of ownership
        rst = 1'b1;
        #2;
        check("t6_gnt", 32'(gnt), 32'h0);
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_bus", 32'(bus_out), 32'hFF);
        rst = 1'b0;
        req = 4'b1010;
        tick();
        check("t6_first", 32'(gnt), 32'h2);
        req = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
